// File: rtl/rob_commit_unit_pkg.sv
// rtl/rob_commit_unit_pkg.sv - shared ROB entry type, sizing and Result field offsets
package rob_commit_unit_pkg;

  localparam int ROB_SIZE = 32;

  // Result message layout as produced by the result queue
  localparam int RES_W       = 49;
  localparam int RES_IDX_HI  = 48;
  localparam int RES_IDX_LO  = 41;
  localparam int RES_MISS    = 40;
  localparam int RES_DATA_HI = 39;
  localparam int RES_DATA_LO = 8;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        dest_valid;
    logic [5:0]  dest;
    logic [31:0] data;
    logic        miss;
  } RobEntry;

  localparam int ENTRY_W = $bits(RobEntry);

endpackage

// File: rtl/rob_storage.sv
// rtl/rob_storage.sv - ROB entry array: alloc write port, complete write port, combinational head read
module rob_storage
  import rob_commit_unit_pkg::*;
#(
  parameter int ROB_SIZE = 32,
  parameter int AW       = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               alloc_we,
  input  logic [AW-1:0]      alloc_idx,
  input  logic               alloc_dest_valid,
  input  logic [5:0]         alloc_dest,
  input  logic               cmp_we,
  input  logic [AW-1:0]      cmp_idx,
  input  logic [31:0]        cmp_data,
  input  logic               cmp_miss,
  output logic               cmp_hit,
  input  logic               retire,
  input  logic [AW-1:0]      head_idx,
  output logic [ENTRY_W-1:0] head_bits
);

  // valid/done live in flops so a flush can wipe them in one edge
  logic [ROB_SIZE-1:0] valid_q;
  logic [ROB_SIZE-1:0] done_q;

  logic        dest_valid_m [ROB_SIZE];
  logic [5:0]  dest_m       [ROB_SIZE];
  logic [31:0] data_m       [ROB_SIZE];
  logic        miss_m       [ROB_SIZE];

  RobEntry head;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      done_q  <= '0;
    end else if (flush) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (retire) valid_q[head_idx] <= 1'b0;
      if (alloc_we) begin
        valid_q[alloc_idx] <= 1'b1;
        done_q[alloc_idx]  <= 1'b0;
      end
      if (cmp_we) done_q[cmp_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (alloc_we) begin
      dest_valid_m[alloc_idx] <= alloc_dest_valid;
      dest_m[alloc_idx]       <= alloc_dest;
    end
    if (cmp_we) begin
      data_m[cmp_idx] <= cmp_data;
      miss_m[cmp_idx] <= cmp_miss;
    end
  end

  always_comb begin
    head.valid      = valid_q[head_idx];
    head.done       = done_q[head_idx];
    head.dest_valid = dest_valid_m[head_idx];
    head.dest       = dest_m[head_idx];
    head.data       = data_m[head_idx];
    head.miss       = miss_m[head_idx];
  end

  assign head_bits = head;
  assign cmp_hit   = valid_q[cmp_idx];

endmodule

// File: rtl/rob_commit_unit.sv
// rtl/rob_commit_unit.sv - in-order ROB commit stage; ROB_RETIRE_CNT_EN adds retire/flash counters
module rob_commit_unit
  import rob_commit_unit_pkg::*;
#(
  parameter int ROB_SIZE = rob_commit_unit_pkg::ROB_SIZE,
  parameter int IDX_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic             alloc_dest_valid,
  input  logic [5:0]       alloc_dest,
  output logic             alloc_reject,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             complete_info_en,
  input  logic [RES_W-1:0] complete_info_msg,
  output logic             complete_info_reject,
  output logic             rf_we,
  output logic [5:0]       rf_addr,
  output logic [31:0]      rf_data,
  output logic             flash,
`ifdef ROB_RETIRE_CNT_EN
  output logic [63:0]      retire_cnt,
  output logic [31:0]      flash_cnt,
`endif
  output logic             rob_empty
);

  localparam int AW = $clog2(ROB_SIZE);
  localparam int CW = IDX_W + 1;
  localparam logic [CW-1:0] SIZE_C = CW'(ROB_SIZE);
  localparam logic [8:0]    SIZE_9 = 9'(ROB_SIZE);

  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [ENTRY_W-1:0] head_bits;
  RobEntry head_e;

  logic [7:0] cmp_idx;
  logic       cmp_in_range, cmp_hit, cmp_we;
  logic       do_alloc, commit;
  logic       unused_msg_bits;

  assign head_e       = RobEntry'(head_bits);
  assign alloc_reject = (count == SIZE_C) | flash;
  assign alloc_idx    = IDX_W'(tail);
  assign rob_empty    = (count == '0);
  assign do_alloc     = alloc_en & ~alloc_reject;
  assign commit       = head_e.valid & head_e.done & ~flash;

  assign complete_info_reject = 1'b0;
  assign cmp_idx      = complete_info_msg[RES_IDX_HI:RES_IDX_LO];
  assign cmp_in_range = ({1'b0, cmp_idx} < SIZE_9);
  // stale results after a flush land on invalid entries and are dropped here
  assign cmp_we       = complete_info_en & ~flash & cmp_in_range & cmp_hit;
  assign unused_msg_bits = ^complete_info_msg[RES_DATA_LO-1:0];

  rob_storage #(.ROB_SIZE(ROB_SIZE), .AW(AW)) u_storage (
    .clock            (clock),
    .reset            (reset),
    .flush            (flash),
    .alloc_we         (do_alloc),
    .alloc_idx        (tail),
    .alloc_dest_valid (alloc_dest_valid),
    .alloc_dest       (alloc_dest),
    .cmp_we           (cmp_we),
    .cmp_idx          (cmp_idx[AW-1:0]),
    .cmp_data         (complete_info_msg[RES_DATA_HI:RES_DATA_LO]),
    .cmp_miss         (complete_info_msg[RES_MISS]),
    .cmp_hit          (cmp_hit),
    .retire           (commit),
    .head_idx         (head),
    .head_bits        (head_bits)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
      flash   <= 1'b0;
    end else if (flash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      rf_we <= 1'b0;
      flash <= 1'b0;
    end else begin
      if (do_alloc) tail <= tail + 1'b1;
      if (commit) begin
        head    <= head + 1'b1;
        rf_addr <= head_e.dest;
        rf_data <= head_e.data;
      end
      count <= count + CW'(do_alloc) - CW'(commit);
      rf_we <= commit & head_e.dest_valid;
      flash <= commit & head_e.miss;
    end
  end

`ifdef ROB_RETIRE_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retire_cnt <= '0;
      flash_cnt  <= '0;
    end else begin
      if (commit) retire_cnt <= retire_cnt + 64'd1;
      if (flash)  flash_cnt  <= flash_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- In-order completion/commit stage directly downstream of the per-reservation-station result queue.
- Holds a reorder buffer (ROB). Dispatch allocates an entry. The result queue's complete_info stream marks the entry done.
- Retires the oldest done entry each cycle: register-file write, plus pipeline flash on a mispredicted branch.

Parameters:
- ROB_SIZE, 32, number of ROB entries; power of two, at most 256.
- IDX_W, 8, width of ROB index fields; matches w8.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- alloc_en  in  1  dispatch requests one entry.
- alloc_dest_valid  in  1  instruction writes a register.
- alloc_dest  in  6  destination register number.
- alloc_reject  out  1  allocation refused this cycle.
- alloc_idx  out  IDX_W  index granted; valid whenever alloc_reject=0.
- complete_info  Message.receive  -  en, msg (Result, 49 bits), reject; driven by the result queue.
- rf_we  out  1  register-file write enable, registered.
- rf_addr  out  6  write address, registered.
- rf_data  out  32  write data, registered.
- flash  out  1  one-cycle pipeline flush pulse, registered.
- rob_empty  out  1  no valid entries.

Behaviour:
- Result fields used: rob_idx[48:41], miss[40], data[39:8]. The remaining bits are ignored.
- State: head, tail (IDX_W bits, mod ROB_SIZE) and count (0..ROB_SIZE).
- Per-entry state: valid, done, dest_valid, dest, data, miss.
- Reset (asynchronous): head, tail and count are 0; all valid bits are 0; rf_we=0, rf_addr=0, rf_data=0, flash=0.
- Allocation:
  - alloc_reject = (count==ROB_SIZE) | flash.
  - alloc_idx = tail, combinational.
  - On alloc_en & ~alloc_reject, at the edge: entry[tail] is written with valid=1, done=0 and the dest fields; tail advances with wrap.
- Completion:
  - complete_info.reject is tied 0.
  - On en while flash=0: if msg.rob_idx < ROB_SIZE and entry valid, set done=1 and capture data and miss.
  - Otherwise drop silently. This covers stale results after a flush and out-of-range indices.
  - en while flash=1 is dropped.
- Commit:
  - Evaluated from state before the edge. If entry[head] is valid & done & flash=0, then at the edge:
    - clear valid and advance head;
    - rf_we <= dest_valid, rf_addr <= dest, rf_data <= data.
  - Otherwise rf_we <= 0. At most one commit per cycle.
- Latency: a completion accepted at edge E becomes committable at edge E+1, with rf_we high during cycle E+1..E+2. No bypass from complete_info to commit.
- Count update: count += alloc − commit, so a simultaneous alloc and commit keeps count unchanged.
  - Full plus commit in the same cycle still rejects the allocation, because full is taken from the pre-edge count.
- Mispredict:
  - A committing entry with miss=1 still performs its rf write.
  - flash <= 1 for exactly one cycle.
  - At the edge where flash=1: head=tail=count=0 and all valid bits are cleared; no commit and no alloc occur that cycle.
  - flash <= 0 afterwards.
- Wrap: head and tail wrap from ROB_SIZE−1 to 0. Full versus empty is distinguished only by count.
- rob_empty = (count==0), combinational.
- Reset asserted mid-operation discards all entries immediately; no rf write is issued.

Optional Feature:
- Macro: ROB_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt [63:0], incremented at every commit edge and reset to 0.
  - Adds output flash_cnt [31:0], incremented on each flash pulse.
  - Neither counter is cleared by flash.
- Undefined: neither port nor its counter exists.

Decomposition:
- Shared package, next to typedefs.svh: RobEntry struct (valid, done, dest_valid, dest[5:0], data[31:0], miss) and the ROB_SIZE constant.
- The Result field-offset localparams also belong in the package.
- Sub-module rob_storage: dual-port entry array with one write port for alloc, one for complete, and a combinational head read.
  - Implemented in distributed RAM for data.
  - Valid and done bits are kept in flops so flash can clear them.

Test Plan:
- Reset; alloc 3 (dest 1,2,3); complete idx 2,0,1 with data 0xA,0xB,0xC → rf writes in order r1=0xB, r2=0xC, r3=0xA; no write before idx0 completes.
- Alloc 32 → 33rd alloc_reject=1; complete and commit idx0, alloc same cycle → still rejected; next cycle accepted with alloc_idx=0 (wrap).
- Alloc 4; complete idx1 with miss=1, then idx0 → commit r(idx0), r(idx1), flash pulse of 1 cycle; rob_empty=1 next cycle; late complete for idx2 ignored; next alloc_idx=0.
- Complete with rob_idx=40, and complete for an unallocated idx 5 → no state change and no rf_we.
- Complete the head entry at edge E → rf_we observed first in cycle after E+1, not earlier.
- Assert reset mid-stream with 5 entries pending → all outputs 0 immediately; after release alloc_idx=0 and rob_empty=1.
